// File: rtl/inst_queue_pkg.sv
// Shared IF/ID definitions: entry layout, exception-type bit indices, widths.
package inst_queue_pkg;

    localparam int EXC_W       = 15;
    localparam int IF_ID_BUS_W = 79;

    // Exception-type bit indices inside exc_type
    localparam int TYPE_SYS  = 0;
    localparam int TYPE_ADEF = 1;
    localparam int TYPE_ALE  = 2;
    localparam int TYPE_BRK  = 3;
    localparam int TYPE_INE  = 4;
    localparam int TYPE_INT  = 5;
    localparam int TYPE_ERTN = 6;
    localparam int TYPE_TLBR = 7;
    localparam int TYPE_PIL  = 8;
    localparam int TYPE_PIS  = 9;
    localparam int TYPE_PIF  = 10;
    localparam int TYPE_PME  = 11;
    localparam int TYPE_PPIF = 12;
    localparam int TYPE_ADEM = 13;
    localparam int TYPE_PPIM = 14;

    // One queued fetch entry, MSB-first as carried on the IF->ID bus
    typedef struct packed {
        logic [EXC_W-1:0] exc_type;
        logic [31:0]      pc;
        logic [31:0]      inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between IF and ID. Circular buffer of DEPTH entries;
// flush/branch-cancel discard everything queued (wrong-path fetches).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = IF_ID_BUS_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             IF_to_IQ_valid,
    input  logic [WIDTH-1:0] IF_to_IQ_bus,
    output logic             IQ_allow_in,
    output logic             IQ_to_ID_valid,
    output logic [WIDTH-1:0] IQ_to_ID_bus,
    input  logic             ID_allow_in,
    input  logic             flush,
    input  logic             br_cancel,
    output logic [PTR_W:0]   iq_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic clear, enq, deq;

    // Handshakes: allow_in only looks at occupancy, so ID never reaches IF combinationally
    assign clear          = flush | br_cancel;
    assign IQ_allow_in    = (count_q != FULL_CNT);
    assign IQ_to_ID_valid = (count_q != '0) & ~clear;
    assign enq            = IF_to_IQ_valid & IQ_allow_in & ~clear;
    assign deq            = IQ_to_ID_valid & ID_allow_in;
    assign IQ_to_ID_bus   = IQ_to_ID_valid ? mem_q[head_q] : '0;
    assign iq_count       = count_q;

    // Next-state for pointers and occupancy; clear wins over everything
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + (PTR_W+1)'(1);
            else if (deq && !enq) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, deliberately not reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= IF_to_IQ_bus;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = IF_ID_BUS_W;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             IF_to_IQ_valid;
    logic [WIDTH-1:0] IF_to_IQ_bus;
    logic             IQ_allow_in;
    logic             IQ_to_ID_valid;
    logic [WIDTH-1:0] IQ_to_ID_bus;
    logic             ID_allow_in;
    logic             flush;
    logic             br_cancel;
    logic [PTR_W:0]   iq_count;

    int n_chk = 0;
    int n_err = 0;

    inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn),
        .IF_to_IQ_valid(IF_to_IQ_valid), .IF_to_IQ_bus(IF_to_IQ_bus),
        .IQ_allow_in(IQ_allow_in),
        .IQ_to_ID_valid(IQ_to_ID_valid), .IQ_to_ID_bus(IQ_to_ID_bus),
        .ID_allow_in(ID_allow_in),
        .flush(flush), .br_cancel(br_cancel),
        .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [EXC_W-1:0] exc, input logic [31:0] pc);
        iq_entry_t e;
        e.exc_type = exc;
        e.pc       = pc;
        e.inst     = ~pc;
        return e;
    endfunction

    // Advance one edge; inputs change 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc0;
        resetn = 1'b0; IF_to_IQ_valid = 1'b0; IF_to_IQ_bus = '0;
        ID_allow_in = 1'b0; flush = 1'b0; br_cancel = 1'b0;
        #3;
        check("rst_allow", WIDTH'(IQ_allow_in), 1);
        check("rst_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("rst_bus", IQ_to_ID_bus, 0);
        check("rst_count", WIDTH'(iq_count), 0);
        #9 resetn = 1'b1;
        tick();

        // 1: fill with ID stalled, then a 5th entry is held off
        for (int i = 0; i < 4; i++) begin
            IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, 32'h1c000000 + 32'(4*i));
            #1;
            check("fill_allow", WIDTH'(IQ_allow_in), 1);
            tick();
        end
        IF_to_IQ_bus = mk('0, 32'h1c000010);
        #1;
        check("full_count", WIDTH'(iq_count), 4);
        check("full_allow", WIDTH'(IQ_allow_in), 0);
        tick();
        IF_to_IQ_valid = 1'b0;
        #1;
        check("held_count", WIDTH'(iq_count), 4);

        // 2: drain in order
        ID_allow_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", WIDTH'(IQ_to_ID_valid), 1);
            check("drain_pc", WIDTH'(IQ_to_ID_bus[63:32]), WIDTH'(32'h1c000000 + 32'(4*i)));
            tick();
        end
        #1;
        check("drained_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("drained_count", WIDTH'(iq_count), 0);
        check("drained_bus", IQ_to_ID_bus, 0);
        tick();

        // 3: streaming enq+deq; count holds at 1, pointers wrap
        pc0 = 32'h1c000100;
        IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, pc0);
        #1;
        check("stream_empty_valid", WIDTH'(IQ_to_ID_valid), 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            IF_to_IQ_bus = mk('0, pc0 + 32'(4*(k+1)));
            #1;
            check("stream_head", IQ_to_ID_bus, mk('0, pc0 + 32'(4*k)));
            check("stream_count", WIDTH'(iq_count), 1);
            tick();
        end
        IF_to_IQ_valid = 1'b0;
        #1;
        check("stream_last", IQ_to_ID_bus, mk('0, pc0 + 32'd40));
        tick();
        #1;
        check("stream_end_count", WIDTH'(iq_count), 0);

        // 4: br_cancel with 3 queued and an incoming entry
        ID_allow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, 32'h1c000200 + 32'(4*i));
            tick();
        end
        IF_to_IQ_bus = mk('0, 32'h1c0002f0); br_cancel = 1'b1; ID_allow_in = 1'b1;
        #1;
        check("bc_count_pre", WIDTH'(iq_count), 3);
        check("bc_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("bc_bus", IQ_to_ID_bus, 0);
        tick();
        br_cancel = 1'b0; IF_to_IQ_valid = 1'b0; ID_allow_in = 1'b0;
        #1;
        check("bc_count", WIDTH'(iq_count), 0);
        check("bc_valid_after", WIDTH'(IQ_to_ID_valid), 0);
        IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, 32'h1c000300);
        tick();
        IF_to_IQ_valid = 1'b0; ID_allow_in = 1'b1;
        #1;
        check("bc_new_head", IQ_to_ID_bus, mk('0, 32'h1c000300));
        check("bc_new_count", WIDTH'(iq_count), 1);
        tick();

        // 5: flush while full, ID ready
        ID_allow_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, 32'h1c000400 + 32'(4*i));
            tick();
        end
        IF_to_IQ_valid = 1'b0; flush = 1'b1; ID_allow_in = 1'b1;
        #1;
        check("fl_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("fl_allow_full", WIDTH'(IQ_allow_in), 0);
        tick();
        flush = 1'b0; ID_allow_in = 1'b0;
        #1;
        check("fl_count", WIDTH'(iq_count), 0);
        check("fl_allow", WIDTH'(IQ_allow_in), 1);

        // 6: exception-tagged entry passes through in order
        IF_to_IQ_valid = 1'b1; IF_to_IQ_bus = mk('0, 32'h1c000500); tick();
        IF_to_IQ_bus = mk(EXC_W'(1) << TYPE_ADEF, 32'h1c000002); tick();
        IF_to_IQ_bus = mk('0, 32'h1c000504); tick();
        IF_to_IQ_valid = 1'b0; ID_allow_in = 1'b1;
        #1; check("exc_0", IQ_to_ID_bus, mk('0, 32'h1c000500)); tick();
        #1; check("exc_1", IQ_to_ID_bus, mk(EXC_W'(1) << TYPE_ADEF, 32'h1c000002)); tick();
        #1; check("exc_2", IQ_to_ID_bus, mk('0, 32'h1c000504)); tick();

        // async reset mid-stream
        ID_allow_in = 1'b0; IF_to_IQ_valid = 1'b1;
        IF_to_IQ_bus = mk('0, 32'h1c000600); tick();
        IF_to_IQ_bus = mk('0, 32'h1c000604); tick();
        IF_to_IQ_valid = 1'b0;
        #1;
        check("pre_rst_count", WIDTH'(iq_count), 2);
        resetn = 1'b0;
        #1;
        check("arst_count", WIDTH'(iq_count), 0);
        check("arst_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("arst_bus", IQ_to_ID_bus, 0);
        check("arst_allow", WIDTH'(IQ_allow_in), 1);
        #1 resetn = 1'b1;
        tick();
        #1;
        check("post_rst_valid", WIDTH'(IQ_to_ID_valid), 0);
        check("post_rst_count", WIDTH'(iq_count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
